// File: rtl/ncc_peak_tracker.sv
// Running-maximum tracker for the NCC PE array output.
// Each accepted beat is one column of LANES signed scores. The best score, lane and column
// seen across a search window are reported on a valid/ready result port once the window's
// last beat has been folded in.
module ncc_peak_tracker #(
  parameter int unsigned LANES    = 16,
  parameter int unsigned W        = 8,
  parameter int unsigned MAX_COLS = 640,
  parameter int          THRESH   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          abort,
  input  logic                          acc_valid,
  output logic                          acc_ready,
  input  logic                          acc_last,
  input  logic [LANES*W-1:0]            acc_data,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic signed [W-1:0]           res_score,
  output logic [$clog2(LANES)-1:0]      res_lane,
  output logic [$clog2(MAX_COLS)-1:0]   res_col,
  output logic                          res_found,
  output logic                          res_overflow
);

  localparam int unsigned LW = $clog2(LANES);
  localparam int unsigned CW = $clog2(MAX_COLS);

  localparam logic signed [W-1:0] MinScore = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] Thresh   = W'(THRESH);
  localparam logic [CW-1:0]       LastCol  = CW'(MAX_COLS - 1);

  typedef enum logic [1:0] {
    StAccum,
    StDrain,
    StHold
  } state_e;

  state_e state_q, state_d;

  logic acc_fire;
  logic res_fire;

  // Stage 1: per-beat lane maximum
  logic signed [W-1:0] lane_max;
  logic [LW-1:0]       lane_idx;
  logic                s1_valid_q;
  logic signed [W-1:0] s1_score_q;
  logic [LW-1:0]       s1_lane_q;
  logic [CW-1:0]       s1_col_q;

  // Column position and window-level flags
  logic [CW-1:0] col_q;
  logic          ovf_q;

  // Running best over the window
  logic signed [W-1:0] best_score_q;
  logic [LW-1:0]       best_lane_q;
  logic [CW-1:0]       best_col_q;

  assign acc_fire = acc_valid & acc_ready;
  assign res_fire = res_valid & res_ready;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StAccum;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and handshake outputs; abort overrides every transition
  always_comb begin
    state_d   = state_q;
    acc_ready = 1'b0;
    res_valid = 1'b0;
    unique case (state_q)
      StAccum: begin
        acc_ready = 1'b1;
        if (acc_valid && acc_last) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        state_d = StHold;
      end
      StHold: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = StAccum;
        end
      end
      default: begin
        state_d = StAccum;
      end
    endcase
    if (abort) begin
      state_d = StAccum;
    end
  end

  // Signed max across lanes; strict compare keeps the lowest lane on ties
  always_comb begin
    lane_max = acc_data[W-1:0];
    lane_idx = '0;
    for (int k = 1; k < LANES; k++) begin
      if ($signed(acc_data[k*W +: W]) > lane_max) begin
        lane_max = acc_data[k*W +: W];
        lane_idx = LW'(k);
      end
    end
  end

  // Stage-1 register, loaded on the beat handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_score_q <= MinScore;
      s1_lane_q  <= '0;
      s1_col_q   <= '0;
    end else if (abort) begin
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= acc_fire;
      if (acc_fire) begin
        s1_score_q <= lane_max;
        s1_lane_q  <= lane_idx;
        s1_col_q   <= col_q;
      end
    end
  end

  // Column counter: saturates at the last column, flagging any beat beyond it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= '0;
      ovf_q <= 1'b0;
    end else if (abort) begin
      col_q <= '0;
      ovf_q <= 1'b0;
    end else if (acc_fire) begin
      if (acc_last) begin
        col_q <= '0;
      end else if (col_q == LastCol) begin
        ovf_q <= 1'b1;
      end else begin
        col_q <= col_q + CW'(1);
      end
    end else if (res_fire) begin
      ovf_q <= 1'b0;
    end
  end

  // Stage 2: fold lane maximum into running best; strict compare keeps the earliest column
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_score_q <= MinScore;
      best_lane_q  <= '0;
      best_col_q   <= '0;
    end else if (abort || res_fire) begin
      best_score_q <= MinScore;
      best_lane_q  <= '0;
      best_col_q   <= '0;
    end else if (s1_valid_q && (s1_score_q > best_score_q)) begin
      best_score_q <= s1_score_q;
      best_lane_q  <= s1_lane_q;
      best_col_q   <= s1_col_q;
    end
  end

  // Result fields are only exposed while the result is being offered
  always_comb begin
    res_score    = '0;
    res_lane     = '0;
    res_col      = '0;
    res_found    = 1'b0;
    res_overflow = 1'b0;
    if (state_q == StHold) begin
      res_score    = best_score_q;
      res_lane     = best_lane_q;
      res_col      = best_col_q;
      res_found    = (best_score_q >= Thresh);
      res_overflow = ovf_q;
    end
  end

endmodule

// File: tb/tb_ncc_peak_tracker.sv
// Bench for ncc_peak_tracker: directed window table, multi-cycle corner sequences and
// randomized windows checked against a whole-window reference model. A second instance
// with a 4-column limit exercises column saturation and overflow.
module tb_ncc_peak_tracker;

  localparam int LANES  = 16;
  localparam int W      = 8;
  localparam int MAXC   = 640;
  localparam int SMALLC = 4;

  typedef struct {
    int sc;
    int ln;
    int cl;
    int fd;
    int ov;
  } res_t;

  // Window: n beats filled with 'fill', up to three (col, lane, value) overrides (col -1 = unused)
  typedef struct {
    int n;
    int fill;
    int c0, l0, v0;
    int c1, l1, v1;
    int c2, l2, v2;
    int sc, ln, cl, fd;
  } dvec_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 abort;
  logic                 acc_valid;
  logic                 acc_last;
  logic [LANES*W-1:0]   acc_data;
  logic                 res_ready;

  logic                 acc_ready, res_valid, res_found, res_overflow;
  logic [W-1:0]         res_score;
  logic [3:0]           res_lane;
  logic [9:0]           res_col;

  logic                 s_acc_ready, s_res_valid, s_res_found, s_res_overflow;
  logic [W-1:0]         s_res_score;
  logic [3:0]           s_res_lane;
  logic [1:0]           s_res_col;

  int n_cmp;
  int n_fail;

  logic [LANES*W-1:0] beats_q[$];
  dvec_t              vecs[8];

  always #5 clk = ~clk;

  ncc_peak_tracker u_dut (
    .clk          (clk),
    .rst          (rst),
    .abort        (abort),
    .acc_valid    (acc_valid),
    .acc_ready    (acc_ready),
    .acc_last     (acc_last),
    .acc_data     (acc_data),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_score    (res_score),
    .res_lane     (res_lane),
    .res_col      (res_col),
    .res_found    (res_found),
    .res_overflow (res_overflow)
  );

  ncc_peak_tracker #(.MAX_COLS(SMALLC)) u_small (
    .clk          (clk),
    .rst          (rst),
    .abort        (abort),
    .acc_valid    (acc_valid),
    .acc_ready    (s_acc_ready),
    .acc_last     (acc_last),
    .acc_data     (acc_data),
    .res_valid    (s_res_valid),
    .res_ready    (res_ready),
    .res_score    (s_res_score),
    .res_lane     (s_res_lane),
    .res_col      (s_res_col),
    .res_found    (s_res_found),
    .res_overflow (s_res_overflow)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [LANES*W-1:0] fill_beat(input int v);
    logic [LANES*W-1:0] b;
    for (int k = 0; k < LANES; k++) b[k*W +: W] = W'(v);
    return b;
  endfunction

  task automatic build(input dvec_t v);
    logic [LANES*W-1:0] b;
    beats_q.delete();
    for (int c = 0; c < v.n; c++) begin
      b = fill_beat(v.fill);
      if (v.c0 == c) b[v.l0*W +: W] = W'(v.v0);
      if (v.c1 == c) b[v.l1*W +: W] = W'(v.v1);
      if (v.c2 == c) b[v.l2*W +: W] = W'(v.v2);
      beats_q.push_back(b);
    end
  endtask

  // Whole-window reference: scan columns then lanes, keep the first strictly larger score
  function automatic res_t model(input int maxc);
    res_t               r;
    logic [LANES*W-1:0] b;
    logic signed [W-1:0] t;
    int                 col;
    r.sc = -(1 << (W - 1));
    r.ln = 0;
    r.cl = 0;
    r.ov = (beats_q.size() > maxc) ? 1 : 0;
    for (int j = 0; j < beats_q.size(); j++) begin
      b   = beats_q[j];
      col = (j < maxc) ? j : maxc - 1;
      for (int k = 0; k < LANES; k++) begin
        t = b[k*W +: W];
        if (int'(t) > r.sc) begin
          r.sc = int'(t);
          r.ln = k;
          r.cl = col;
        end
      end
    end
    r.fd = (r.sc >= 0) ? 1 : 0;
    return r;
  endfunction

  task automatic drive_beat(input logic [LANES*W-1:0] b, input logic last, input int idle,
                            output bit ok);
    int to;
    acc_valid = 1'b0;
    repeat (idle) step();
    acc_data  = b;
    acc_last  = last;
    acc_valid = 1'b1;
    check("beat_acc_ready", int'(acc_ready), 1);
    to = 0;
    while (!acc_ready && to < 16) begin
      step();
      to++;
    end
    if (!acc_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL beat_timeout: acc_ready got 0 expected 1");
      ok = 1'b0;
    end else begin
      step();
      ok = 1'b1;
    end
    acc_valid = 1'b0;
    acc_last  = 1'b0;
  endtask

  task automatic send_window(input int idle_max, output bit ok);
    bit bok;
    ok = 1'b1;
    for (int i = 0; i < beats_q.size(); i++) begin
      if (ok) begin
        drive_beat(beats_q[i], (i == beats_q.size() - 1), $urandom_range(0, idle_max), bok);
        ok = ok & bok;
      end
    end
  endtask

  // Called right after the last-beat handshake edge
  task automatic collect(input int dly, input res_t em, input res_t es);
    int to;
    check("drain_res_valid", int'(res_valid), 0);
    check("drain_acc_ready", int'(acc_ready), 0);
    step();
    check("latency_res_valid", int'(res_valid), 1);
    to = 0;
    while (!res_valid && to < 8) begin
      step();
      to++;
    end
    repeat (dly) begin
      step();
      check("hold_res_valid", int'(res_valid), 1);
    end
    check("score", int'($signed(res_score)), em.sc);
    check("lane", int'(res_lane), em.ln);
    check("col", int'(res_col), em.cl);
    check("found", int'(res_found), em.fd);
    check("overflow", int'(res_overflow), em.ov);
    check("small_res_valid", int'(s_res_valid), 1);
    check("small_score", int'($signed(s_res_score)), es.sc);
    check("small_lane", int'(s_res_lane), es.ln);
    check("small_col", int'(s_res_col), es.cl);
    check("small_found", int'(s_res_found), es.fd);
    check("small_overflow", int'(s_res_overflow), es.ov);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("release_res_valid", int'(res_valid), 0);
    check("release_acc_ready", int'(acc_ready), 1);
  endtask

  initial begin
    bit                 ok;
    res_t               e;
    dvec_t              v;
    logic [LANES*W-1:0] b;
    int                 pool[5];

    n_cmp     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    abort     = 1'b0;
    acc_valid = 1'b0;
    acc_last  = 1'b0;
    acc_data  = '0;
    res_ready = 1'b0;
    pool      = '{-128, -1, 0, 5, 127};

    //        n  fill  c0 l0  v0    c1 l1  v1    c2 l2  v2    sc  ln cl fd
    vecs[0] = '{4, -3,    2, 5, 100,  -1, 0, 0,    -1, 0, 0,   100,  5, 2, 1};
    vecs[1] = '{1, -128, -1, 0, 0,    -1, 0, 0,    -1, 0, 0,  -128,  0, 0, 0};
    vecs[2] = '{5, -3,    1, 3, 50,    1, 9, 50,    4, 0, 50,   50,  3, 1, 1};
    vecs[3] = '{3, 0,    -1, 0, 0,    -1, 0, 0,    -1, 0, 0,     0,  0, 0, 1};
    vecs[4] = '{3, -1,    2, 15, 127, -1, 0, 0,    -1, 0, 0,   127, 15, 2, 1};
    vecs[5] = '{2, -1,   -1, 0, 0,    -1, 0, 0,    -1, 0, 0,    -1,  0, 0, 0};
    vecs[6] = '{4, -128,  3, 7, -127, -1, 0, 0,    -1, 0, 0,  -127,  7, 3, 0};
    vecs[7] = '{3, -128,  2, 12, -100, 1, 12, -100, -1, 0, 0, -100, 12, 1, 0};

    repeat (2) @(posedge clk);
    #1;
    check("rst_acc_ready", int'(acc_ready), 1);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_score", int'($signed(res_score)), 0);
    check("rst_lane", int'(res_lane), 0);
    check("rst_col", int'(res_col), 0);
    check("rst_found", int'(res_found), 0);
    check("rst_overflow", int'(res_overflow), 0);
    check("rst_small_res_valid", int'(s_res_valid), 0);
    rst = 1'b0;
    step();

    // Directed window table
    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      build(v);
      send_window(0, ok);
      e = '{v.sc, v.ln, v.cl, v.fd, 0};
      if (ok) collect(i % 3, e, model(SMALLC));
    end

    // Result held under back-pressure while beats are offered
    build(vecs[0]);
    send_window(0, ok);
    step();
    for (int i = 0; i < 10; i++) begin
      acc_valid = 1'b1;
      acc_data  = {$urandom, $urandom, $urandom, $urandom};
      acc_last  = 1'($urandom);
      check("bp_acc_ready", int'(acc_ready), 0);
      check("bp_res_valid", int'(res_valid), 1);
      check("bp_score", int'($signed(res_score)), 100);
      check("bp_lane", int'(res_lane), 5);
      check("bp_col", int'(res_col), 2);
      step();
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("bp_release_acc_ready", int'(acc_ready), 1);
    check("bp_release_res_valid", int'(res_valid), 0);
    acc_valid = 1'b0;
    acc_last  = 1'b0;
    step();

    // Column saturation: six beats, maximum on the sixth
    v = '{6, -3, 5, 2, 90, -1, 0, 0, -1, 0, 0, 90, 2, 5, 1};
    build(v);
    send_window(0, ok);
    if (ok) collect(1, '{90, 2, 5, 1, 0}, '{90, 2, 3, 1, 1});

    // Abort on the same edge as the third accepted beat of five
    v = '{5, -3, 0, 4, 120, -1, 0, 0, -1, 0, 0, 0, 0, 0, 0};
    build(v);
    drive_beat(beats_q[0], 1'b0, 0, ok);
    drive_beat(beats_q[1], 1'b0, 0, ok);
    acc_data  = beats_q[2];
    acc_last  = 1'b0;
    acc_valid = 1'b1;
    abort     = 1'b1;
    step();
    abort     = 1'b0;
    acc_valid = 1'b0;
    check("abort_acc_ready", int'(acc_ready), 1);
    check("abort_res_valid", int'(res_valid), 0);
    step();
    step();
    check("abort_no_result", int'(res_valid), 0);
    v = '{2, -3, 1, 1, 7, -1, 0, 0, -1, 0, 0, 7, 1, 1, 1};
    build(v);
    send_window(0, ok);
    if (ok) collect(0, '{7, 1, 1, 1, 0}, model(SMALLC));

    // Abort while the result is being offered
    build(vecs[4]);
    send_window(0, ok);
    step();
    check("hold_abort_pre_valid", int'(res_valid), 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("hold_abort_res_valid", int'(res_valid), 0);
    check("hold_abort_acc_ready", int'(acc_ready), 1);
    build(vecs[5]);
    send_window(0, ok);
    if (ok) collect(0, '{-1, 0, 0, 0, 0}, model(SMALLC));

    // Asynchronous reset in the middle of a window
    b = fill_beat(120);
    drive_beat(b, 1'b0, 0, ok);
    drive_beat(b, 1'b0, 0, ok);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_acc_ready", int'(acc_ready), 1);
    check("midrst_res_valid", int'(res_valid), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    build(vecs[5]);
    send_window(0, ok);
    if (ok) collect(0, '{-1, 0, 0, 0, 0}, model(SMALLC));

    // Randomized windows against the reference model
    for (int w = 0; w < 30; w++) begin
      beats_q.delete();
      for (int c = 0; c < $urandom_range(1, 8); c++) begin
        for (int k = 0; k < LANES; k++) begin
          if ($urandom_range(0, 3) == 0) b[k*W +: W] = W'(pool[$urandom_range(0, 4)]);
          else b[k*W +: W] = W'($urandom);
        end
        beats_q.push_back(b);
      end
      send_window(1, ok);
      if (ok) collect($urandom_range(0, 3), model(MAXC), model(SMALLC));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
